// File: rtl/program_loader.sv
// program_loader: boot-time loader for a framed program image.
// Receives a byte stream framed as
//   0xA5, N[7:0], N[15:8], 4N payload bytes (big-endian words), XOR checksum.
// Each payload word is written to instruction memory. The CPU is held in
// reset until the whole image is written and the checksum matches.
//
// Ports:
//   clk             rising-edge clock
//   reset_in        synchronous, active-high reset
//   rx_valid_in     byte available on rx_data_in
//   rx_data_in      stream byte
//   rx_ready_out    loader can accept a byte (low only during a write cycle)
//   imem_wr_en_out  one-cycle instruction-memory write strobe
//   imem_addr_out   word-aligned byte address of the write
//   imem_data_out   write data
//   cpu_reset_out   1 = hold CPU in reset
//   done_out        image loaded and verified
//   error_out       framing or checksum error
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset_in,
  input  logic        rx_valid_in,
  input  logic [7:0]  rx_data_in,
  output logic        rx_ready_out,
  output logic        imem_wr_en_out,
  output logic [31:0] imem_addr_out,
  output logic [31:0] imem_data_out,
  output logic        cpu_reset_out,
  output logic        done_out,
  output logic        error_out
);

  localparam logic [7:0] MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  state_e      state_q;
  logic [15:0] len_q;       // word count N of the current frame
  logic [15:0] idx_q;       // index of the word being assembled / written
  logic [1:0]  byte_cnt_q;  // payload bytes already shifted into asm_q
  logic [23:0] asm_q;       // first three bytes of the word being assembled
  logic [7:0]  csum_q;      // running XOR of payload bytes

  logic        rx_ready_q;
  logic        wr_en_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        cpu_reset_q;
  logic        done_q;
  logic        error_q;

  // Byte transfer handshake.
  logic accept;
  assign accept = rx_valid_in && rx_ready_q;

  // Combinational helpers feeding the registers.
  logic [15:0] len_d;
  logic        len_bad_d;
  logic [31:0] word_d;
  logic [31:0] addr_d;

  always_comb begin
    len_d     = {rx_data_in, len_q[7:0]};
    len_bad_d = (len_d == 16'd0) || (32'(len_d) > MAX_WORDS);
    word_d    = {asm_q, rx_data_in};
    addr_d    = BASE_ADDR + (32'(idx_q) << 2);
  end

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q     <= S_IDLE;
      len_q       <= 16'd0;
      idx_q       <= 16'd0;
      byte_cnt_q  <= 2'd0;
      asm_q       <= 24'd0;
      csum_q      <= 8'd0;
      rx_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      // The strobe lasts one cycle; ready is dropped only on entry to WRITE.
      wr_en_q    <= 1'b0;
      rx_ready_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          // Anything other than the magic byte is consumed and dropped.
          if (accept && (rx_data_in == MAGIC)) begin
            state_q <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (accept) begin
            len_q[7:0] <= rx_data_in;
            state_q    <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (accept) begin
            len_q[15:8] <= rx_data_in;
            if (len_bad_d) begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end else begin
              state_q    <= S_DATA;
              idx_q      <= 16'd0;
              byte_cnt_q <= 2'd0;
              csum_q     <= 8'd0;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            asm_q      <= word_d[23:0];
            csum_q     <= csum_q ^ rx_data_in;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            // Fourth byte completes the word: present it during WRITE.
            if (byte_cnt_q == 2'd3) begin
              state_q    <= S_WRITE;
              wr_en_q    <= 1'b1;
              addr_q     <= addr_d;
              data_q     <= word_d;
              rx_ready_q <= 1'b0;
            end
          end
        end

        S_WRITE: begin
          idx_q <= idx_q + 16'd1;
          if (idx_q == (len_q - 16'd1)) begin
            state_q <= S_CHECK;
          end else begin
            state_q <= S_DATA;
          end
        end

        S_CHECK: begin
          if (accept) begin
            if (rx_data_in == csum_q) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
        end

        S_DONE, S_ERROR: begin
          // Only a new magic byte restarts; the CPU goes back into reset.
          if (accept && (rx_data_in == MAGIC)) begin
            state_q     <= S_LEN_LO;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_ready_out   = rx_ready_q;
  assign imem_wr_en_out = wr_en_q;
  assign imem_addr_out  = addr_q;
  assign imem_data_out  = data_q;
  assign cpu_reset_out  = cpu_reset_q;
  assign done_out       = done_q;
  assign error_out      = error_q;

endmodule
